load_store_unit: RTL and testbench

//  Memory-stage front end between the EX/MEM pipeline register and the word-addressed data memory.

---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/byte_lane_align.sv | 20 ++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store unit.
// Lanes are little-endian: byte k lives in bits [8k+7:8k].
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } lsu_state_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  addr,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{addr, 3'b000} +: 8];
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = is_unsigned ? {24'd0, b} : 32'(b);
      SIZE_HALF: r = is_unsigned ? {16'd0, h} : 32'(h);
      default:   r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  addr,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: r[{addr, 3'b000} +: 8] = wdata[7:0];
      SIZE_HALF: begin
        if (addr[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default:   r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane steering: extract/extend the addressed lane for loads,
// and splice store data into the read word for sub-word stores.
import lsu_pkg::*;

module byte_lane_align (
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  always_comb begin
    load_data   = lane_extract(rd_word, addr, size, is_unsigned);
    merged_word = lane_merge(rd_word, wdata, addr, size);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end: byte-addressed requests to word memory,
// read-modify-write for sub-word stores, error detection and ready/valid stall.
import lsu_pkg::*;

module load_store_unit #(
  parameter int ADDR_WORDS  = 512,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_UNSIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITE_DATA,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  input  logic [31:0] MEM_READ_DATA
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;
  logic             accept;
  logic             req_err;

  logic [31:0]      addr_p1;
  logic [31:0]      wdata_p1;
  logic [31:0]      rdata_p1;
  logic [1:0]       size_p1;
  logic             write_p1;
  logic             uns_p1;

  logic [31:0]      load_data;
  logic [31:0]      merged_word;

  assign accept   = REQ_VALID && (state == ST_IDLE);
  assign cnt_done = (cnt == '0);

  always_comb begin
    req_err = 1'b0;
    case (REQ_SIZE)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = REQ_ADDR[0];
      SIZE_WORD: req_err = (REQ_ADDR[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
    if (REQ_ADDR[31:2] >= 30'(ADDR_WORDS)) req_err = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err)                                state_next = ST_ERR;
          else if (REQ_WRITE && REQ_SIZE == SIZE_WORD) state_next = ST_WRITE;
          else                                        state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_WAIT;
      ST_WAIT:  if (cnt_done) state_next = write_p1 ? ST_WRITE : ST_RESP;
      ST_WRITE: state_next = ST_RESP;
      ST_ERR:   state_next = ST_IDLE;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Control: FSM state and memory latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_READ)                cnt <= CNT_W'(MEM_LATENCY - 1);
      else if (state == ST_WAIT && !cnt_done) cnt <= cnt - CNT_W'(1);
    end
  end

  // Request latch, then read-word capture in the last wait cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= REQ_ADDR;
      size_p1  <= REQ_SIZE;
      write_p1 <= REQ_WRITE;
      uns_p1   <= REQ_UNSIGNED;
      wdata_p1 <= REQ_WDATA;
    end
    if (state == ST_WAIT && cnt_done) begin
      rdata_p1 <= load_data;
      if (write_p1) wdata_p1 <= merged_word;
    end
  end

  byte_lane_align u_align (
    .rd_word     (MEM_READ_DATA),
    .wdata       (wdata_p1),
    .addr        (addr_p1[1:0]),
    .size        (size_p1),
    .is_unsigned (uns_p1),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Write strobe is masked by rst so an aborting reset edge never commits a partial RMW.
  always_comb begin
    REQ_READY      = (state == ST_IDLE);
    MEM_READ       = (state == ST_READ);
    MEM_WRITE      = (state == ST_WRITE) && !rst;
    MEM_WRITE_DATA = (state == ST_WRITE) ? wdata_p1 : 32'd0;
    MEM_ADDRESS    = 32'd0;
    if (state == ST_READ || state == ST_WAIT || state == ST_WRITE || state == ST_RESP)
      MEM_ADDRESS = {2'b00, addr_p1[31:2]};
    RESP_VALID     = (state == ST_RESP) || (state == ST_ERR);
    RESP_ERR       = (state == ST_ERR);
    RESP_RDATA     = (state == ST_RESP && !write_p1) ? rdata_p1 : 32'd0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at latency 1, one at latency 3,
// each backed by a small word memory preloaded with word[i]=i.
module tb_load_store_unit;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_init;
  logic        req_valid, req_valid3;
  logic        req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        req_ready3, resp_valid3, resp_err3, mem_read3, mem_write3;
  logic [31:0] resp_rdata3, mem_address3, mem_write_data3, mem_read_data3;

  logic [31:0] mem1 [512];
  logic [31:0] mem3 [512];
  logic [31:0] d3   [3];

  load_store_unit #(.ADDR_WORDS(512), .MEM_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
    .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .RESP_VALID(resp_valid), .RESP_RDATA(resp_rdata),
    .RESP_ERR(resp_err), .MEM_ADDRESS(mem_address), .MEM_WRITE_DATA(mem_write_data),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_READ_DATA(mem_read_data)
  );

  load_store_unit #(.ADDR_WORDS(512), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .REQ_VALID(req_valid3), .REQ_READY(req_ready3), .REQ_WRITE(req_write),
    .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .RESP_VALID(resp_valid3), .RESP_RDATA(resp_rdata3),
    .RESP_ERR(resp_err3), .MEM_ADDRESS(mem_address3), .MEM_WRITE_DATA(mem_write_data3),
    .MEM_READ(mem_read3), .MEM_WRITE(mem_write3), .MEM_READ_DATA(mem_read_data3)
  );

  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 512; i++) mem1[i] <= 32'(i);
    if (mem_read)  mem_read_data <= mem1[mem_address[8:0]];
    if (mem_write) mem1[mem_address[8:0]] <= mem_write_data;
  end

  always @(posedge clk) begin
    if (mem_init) for (int j = 0; j < 512; j++) mem3[j] <= 32'(j);
    if (mem_read3) d3[0] <= mem3[mem_address3[8:0]];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
    if (mem_write3) mem3[mem_address3[8:0]] <= mem_write_data3;
  end
  assign mem_read_data3 = d3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  int          rd_cyc, wr_cyc, resp_cyc;
  logic [31:0] rd_addr, wr_addr, wr_data, resp_data;
  logic        resp_e, overlap_any;

  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    rd_cyc = -1; wr_cyc = -1; resp_cyc = -1;
    rd_addr = 0; wr_addr = 0; wr_data = 0; resp_data = 0; resp_e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read && mem_write) overlap_any = 1'b1;
      if (mem_read && rd_cyc < 0) begin rd_cyc = k; rd_addr = mem_address; end
      if (mem_write && wr_cyc < 0) begin
        wr_cyc = k; wr_addr = mem_address; wr_data = mem_write_data;
      end
      if (resp_valid) begin
        resp_cyc = k; resp_data = resp_rdata; resp_e = resp_err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_txn(input string tag, input int e_rd, input int e_wr, input int e_resp,
                           input logic [31:0] e_data, input logic e_err);
    check_val({tag, ".rd_cyc"},   rd_cyc,    e_rd);
    check_val({tag, ".wr_cyc"},   wr_cyc,    e_wr);
    check_val({tag, ".resp_cyc"}, resp_cyc,  e_resp);
    check_val({tag, ".rdata"},    resp_data, e_data);
    check_val({tag, ".err"},      {31'd0, resp_e}, {31'd0, e_err});
    check_val({tag, ".ready"},    {31'd0, req_ready}, 32'd1);
  endtask

  logic        saw_wr;
  logic        rd3 [1:12];
  logic        rdy3[1:12];
  logic        rv3 [1:12];
  logic [31:0] rdat3[1:12];
  int          n_rd3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_init = 1'b1; overlap_any = 1'b0;
    req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0; req_size = SZ_B;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    @(posedge clk); #1;
    mem_init = 1'b0;
    @(posedge clk); #1;
    check_val("rst.ready",      {31'd0, req_ready},  32'd1);
    check_val("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst.mem_read",   {31'd0, mem_read},   32'd0);
    check_val("rst.mem_write",  {31'd0, mem_write},  32'd0);
    check_val("rst.mem_addr",   mem_address,         32'd0);
    check_val("rst.rdata",      resp_rdata,          32'd0);
    check_val("rst.ready3",     {31'd0, req_ready3}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word load and byte/half store-then-load round trips
    run_req(1'b0, SZ_W, 1'b0, 32'h10, 32'd0);
    check_txn("ld_w_10", 1, -1, 3, 32'h00000004, 1'b0);
    check_val("ld_w_10.addr", rd_addr, 32'd4);

    run_req(1'b1, SZ_B, 1'b0, 32'h21, 32'h000000AB);
    check_txn("st_b_21", 1, 3, 4, 32'd0, 1'b0);
    check_val("st_b_21.waddr", wr_addr, 32'd8);
    check_val("st_b_21.wdata", wr_data, 32'h0000AB08);
    check_val("st_b_21.mem8",  mem1[8], 32'h0000AB08);

    run_req(1'b0, SZ_B, 1'b0, 32'h21, 32'd0);
    check_txn("ld_bs_21", 1, -1, 3, 32'hFFFFFFAB, 1'b0);
    run_req(1'b0, SZ_B, 1'b1, 32'h21, 32'd0);
    check_txn("ld_bu_21", 1, -1, 3, 32'h000000AB, 1'b0);
    run_req(1'b0, SZ_B, 1'b0, 32'h20, 32'd0);
    check_txn("ld_bs_20", 1, -1, 3, 32'h00000008, 1'b0);

    run_req(1'b1, SZ_H, 1'b0, 32'h0E, 32'h00008001);
    check_txn("st_h_0e", 1, 3, 4, 32'd0, 1'b0);
    check_val("st_h_0e.wdata", wr_data, 32'h80010003);
    check_val("st_h_0e.mem3",  mem1[3], 32'h80010003);
    run_req(1'b0, SZ_H, 1'b0, 32'h0E, 32'd0);
    check_txn("ld_hs_0e", 1, -1, 3, 32'hFFFF8001, 1'b0);
    run_req(1'b0, SZ_H, 1'b1, 32'h0C, 32'd0);
    check_txn("ld_hu_0c", 1, -1, 3, 32'h00000003, 1'b0);

    // Word store goes straight to write, no read
    run_req(1'b1, SZ_W, 1'b0, 32'h14, 32'hDEADBEEF);
    check_txn("st_w_14", -1, 1, 2, 32'd0, 1'b0);
    check_val("st_w_14.waddr", wr_addr, 32'd5);
    check_val("st_w_14.wdata", wr_data, 32'hDEADBEEF);
    run_req(1'b0, SZ_W, 1'b0, 32'h14, 32'd0);
    check_txn("ld_w_14", 1, -1, 3, 32'hDEADBEEF, 1'b0);

    // Error cases and the last in-range word
    run_req(1'b0, SZ_W, 1'b0, 32'h06, 32'd0);
    check_txn("err_w_06", -1, -1, 1, 32'd0, 1'b1);
    run_req(1'b0, SZ_W, 1'b0, 32'h800, 32'd0);
    check_txn("err_w_800", -1, -1, 1, 32'd0, 1'b1);
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    check_txn("err_sz11", -1, -1, 1, 32'd0, 1'b1);
    run_req(1'b1, SZ_H, 1'b0, 32'h01, 32'h1234);
    check_txn("err_st_h_01", -1, -1, 1, 32'd0, 1'b1);
    run_req(1'b0, SZ_W, 1'b0, 32'h7FC, 32'd0);
    check_txn("ld_w_7fc", 1, -1, 3, 32'h000001FF, 1'b0);

    // Reset during the wait of a byte-store RMW
    saw_wr = 1'b0;
    req_write = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h000000CD; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    saw_wr |= mem_write;
    @(posedge clk); #1;
    saw_wr |= mem_write;
    rst = 1'b1;
    @(posedge clk); #1;
    saw_wr |= mem_write;
    check_val("rst_mid.ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      saw_wr |= mem_write;
    end
    check_val("rst_mid.no_write", {31'd0, saw_wr}, 32'd0);
    check_val("rst_mid.mem8",     mem1[8],         32'h0000AB08);

    // Latency 3, request held across two loads
    req_write = 1'b0; req_size = SZ_W; req_unsigned = 1'b0; req_addr = 32'h10;
    req_valid3 = 1'b1;
    n_rd3 = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      rd3[k] = mem_read3; rdy3[k] = req_ready3; rv3[k] = resp_valid3; rdat3[k] = resp_rdata3;
      if (mem_read3) n_rd3++;
      if (k == 7) req_valid3 = 1'b0;
    end
    check_val("l3.rd_a1",    {31'd0, rd3[1]},  32'd1);
    check_val("l3.resp_a4",  {31'd0, rv3[4]},  32'd0);
    check_val("l3.resp_a5",  {31'd0, rv3[5]},  32'd1);
    check_val("l3.rdata_a5", rdat3[5],         32'h00000004);
    check_val("l3.ready_a5", {31'd0, rdy3[5]}, 32'd0);
    check_val("l3.ready_a6", {31'd0, rdy3[6]}, 32'd1);
    check_val("l3.rd_a7",    {31'd0, rd3[7]},  32'd1);
    check_val("l3.resp_a11", {31'd0, rv3[11]}, 32'd1);
    check_val("l3.rdata_a11", rdat3[11],       32'h00000004);
    check_val("l3.n_reads",  n_rd3,            32'd2);

    check_val("rd_wr_overlap", {31'd0, overlap_any}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
